// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester tags, request bundle and arbiter FSM states.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        REQ_FETCH,
        REQ_READ,
        REQ_WRITE
    } req_id_e;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    typedef enum logic {
        ARB,
        HOLD
    } arb_state_e;

    // Loads and fetches carry zero data so the memory bus is quiet on non-store requests.
    function automatic mem_req_t make_req(input logic                  write,
                                          input logic [MEM_ADDR_W-1:0] addr,
                                          input logic [MEM_DATA_W-1:0] data);
        mem_req_t r;
        r.write = write;
        r.addr  = addr;
        r.data  = write ? data : '0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of requester tags for issued-but-unanswered memory requests.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  req_id_e          push_id,
    input  logic             pop,
    output req_id_e          head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_id_e          tags [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = tags[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            tags[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory request port between fetch, load and store requesters and
// routes in-order memory responses back to whichever requester issued them.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           fetch_req_valid,
    input  logic [ADDR_W-1:0]              fetch_req_addr,
    output logic                           fetch_req_ready,
    output logic                           fetch_rsp_valid,
    output logic [DATA_W-1:0]              fetch_rsp_data,
    input  logic                           read_req_valid,
    input  logic [ADDR_W-1:0]              read_req_addr,
    output logic                           read_req_ready,
    output logic                           read_rsp_valid,
    output logic [DATA_W-1:0]              read_rsp_data,
    output logic [1:0]                     read_rsp_resv,
    input  logic                           write_req_valid,
    input  logic [ADDR_W-1:0]              write_req_addr,
    input  logic [DATA_W-1:0]              write_req_data,
    output logic                           write_req_ready,
    output logic                           write_rsp_valid,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_write,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic [DATA_W-1:0]              mem_req_data,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_W-1:0]              mem_rsp_data,
    input  logic [1:0]                     mem_rsp_resv,
    output logic [$clog2(MAX_OUTST+1)-1:0] outstanding,
    output logic                           err_unexp_rsp
);

    localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

    arb_state_e          state;
    logic [STARVE_W-1:0] starve_cnt;
    req_id_e             hold_id;
    mem_req_t            hold_req;

    req_id_e             win_id;
    mem_req_t            win_req;
    logic                win_valid;
    req_id_e             pres_id;
    mem_req_t            pres_req;
    logic                pres_valid;
    logic                issue;

    logic                fifo_full;
    logic                fifo_empty;
    req_id_e             head_id;
    logic [CNT_W-1:0]    fifo_count;
    logic                rsp_pop;

    always_comb begin
        win_id = REQ_FETCH;
        if (fetch_req_valid && starve_cnt == STARVE_W'(STARVE_LIM)) begin
            win_id = REQ_FETCH;
        end else if (write_req_valid) begin
            win_id = REQ_WRITE;
        end else if (read_req_valid) begin
            win_id = REQ_READ;
        end
        win_valid = (fetch_req_valid || read_req_valid || write_req_valid) && !fifo_full;
    end

    always_comb begin
        case (win_id)
            REQ_WRITE: win_req = make_req(1'b1, MEM_ADDR_W'(write_req_addr), MEM_DATA_W'(write_req_data));
            REQ_READ:  win_req = make_req(1'b0, MEM_ADDR_W'(read_req_addr), '0);
            default:   win_req = make_req(1'b0, MEM_ADDR_W'(fetch_req_addr), '0);
        endcase
    end

    // In HOLD the latched winner is presented verbatim; live requests are ignored until accepted.
    always_comb begin
        pres_valid = 1'b0;
        pres_id    = win_id;
        pres_req   = win_req;
        if (!RESET) begin
            if (state == HOLD) begin
                pres_valid = 1'b1;
                pres_id    = hold_id;
                pres_req   = hold_req;
            end else begin
                pres_valid = win_valid;
            end
        end
    end

    assign issue           = pres_valid && mem_req_ready;
    assign mem_req_valid   = pres_valid;
    assign mem_req_write   = pres_valid && pres_req.write;
    assign mem_req_addr    = ADDR_W'(pres_req.addr);
    assign mem_req_data    = pres_req.write ? DATA_W'(pres_req.data) : '0;
    assign fetch_req_ready = issue && (pres_id == REQ_FETCH);
    assign read_req_ready  = issue && (pres_id == REQ_READ);
    assign write_req_ready = issue && (pres_id == REQ_WRITE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ARB;
            hold_id  <= REQ_FETCH;
            hold_req <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (win_valid && !mem_req_ready) begin
                        state    <= HOLD;
                        hold_id  <= win_id;
                        hold_req <= win_req;
                    end
                end
                HOLD: begin
                    if (mem_req_ready) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (fetch_req_valid && !fetch_req_ready) begin
            if (starve_cnt != STARVE_W'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_unexp_rsp <= 1'b0;
        end else if (mem_rsp_valid && fifo_empty) begin
            err_unexp_rsp <= 1'b1;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (issue),
        .push_id (pres_id),
        .pop     (rsp_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign outstanding     = fifo_count;
    assign rsp_pop         = !RESET && mem_rsp_valid && !fifo_empty;
    assign fetch_rsp_valid = rsp_pop && (head_id == REQ_FETCH);
    assign read_rsp_valid  = rsp_pop && (head_id == REQ_READ);
    assign write_rsp_valid = rsp_pop && (head_id == REQ_WRITE);
    assign fetch_rsp_data  = mem_rsp_data;
    assign read_rsp_data   = mem_rsp_data;
    assign read_rsp_resv   = mem_rsp_resv;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a queue model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_OUTST  = 4;
    localparam int STARVE_LIM = 8;
    localparam int CNT_W      = $clog2(MAX_OUTST + 1);

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              fetch_req_valid = 1'b0;
    logic [ADDR_W-1:0] fetch_req_addr = '0;
    logic              fetch_req_ready;
    logic              fetch_rsp_valid;
    logic [DATA_W-1:0] fetch_rsp_data;
    logic              read_req_valid = 1'b0;
    logic [ADDR_W-1:0] read_req_addr = '0;
    logic              read_req_ready;
    logic              read_rsp_valid;
    logic [DATA_W-1:0] read_rsp_data;
    logic [1:0]        read_rsp_resv;
    logic              write_req_valid = 1'b0;
    logic [ADDR_W-1:0] write_req_addr = '0;
    logic [DATA_W-1:0] write_req_data = '0;
    logic              write_req_ready;
    logic              write_rsp_valid;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data = '0;
    logic [1:0]        mem_rsp_resv = '0;
    logic [CNT_W-1:0]  outstanding;
    logic              err_unexp_rsp;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_OUTST  (MAX_OUTST),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_addr  (fetch_req_addr),
        .fetch_req_ready (fetch_req_ready),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_data  (fetch_rsp_data),
        .read_req_valid  (read_req_valid),
        .read_req_addr   (read_req_addr),
        .read_req_ready  (read_req_ready),
        .read_rsp_valid  (read_rsp_valid),
        .read_rsp_data   (read_rsp_data),
        .read_rsp_resv   (read_rsp_resv),
        .write_req_valid (write_req_valid),
        .write_req_addr  (write_req_addr),
        .write_req_data  (write_req_data),
        .write_req_ready (write_req_ready),
        .write_rsp_valid (write_rsp_valid),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .mem_rsp_resv    (mem_rsp_resv),
        .outstanding     (outstanding),
        .err_unexp_rsp   (err_unexp_rsp)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: requester ids 0=fetch 1=read 2=write.
    int          tagq[$];
    bit          m_known = 0;
    bit          m_locked = 0;
    int          m_lock_who = 0;
    logic [31:0] m_lock_addr = '0;
    logic [31:0] m_lock_data = '0;
    int          m_starve = 0;
    bit          m_err = 0;
    bit          last_acc;
    int          last_who;

    logic              obs_req_valid, obs_fr, obs_rr, obs_wr, obs_frv, obs_rrv, obs_wrv, obs_err;
    logic [ADDR_W-1:0] obs_addr;
    logic [DATA_W-1:0] obs_rdata, obs_fdata;
    logic [CNT_W-1:0]  obs_out;

    function automatic logic [31:0] addr_of(input int who);
        return (who == 2) ? write_req_addr : (who == 1) ? read_req_addr : fetch_req_addr;
    endfunction

    task automatic step();
        bit grant, acc, pop;
        int who, rsp_who;
        logic [31:0] e_addr, e_data;
        #3;
        obs_req_valid = mem_req_valid; obs_addr = mem_req_addr;
        obs_fr = fetch_req_ready; obs_rr = read_req_ready; obs_wr = write_req_ready;
        obs_frv = fetch_rsp_valid; obs_rrv = read_rsp_valid; obs_wrv = write_rsp_valid;
        obs_fdata = fetch_rsp_data; obs_rdata = read_rsp_data;
        obs_out = outstanding; obs_err = err_unexp_rsp;

        grant = 0; who = 0;
        if (!RESET) begin
            if (m_locked) begin
                grant = 1; who = m_lock_who;
            end else if (tagq.size() < MAX_OUTST) begin
                if (fetch_req_valid && m_starve >= STARVE_LIM) begin grant = 1; who = 0; end
                else if (write_req_valid) begin grant = 1; who = 2; end
                else if (read_req_valid) begin grant = 1; who = 1; end
                else if (fetch_req_valid) begin grant = 1; who = 0; end
            end
        end
        e_addr = m_locked ? m_lock_addr : addr_of(who);
        e_data = (who != 2) ? 32'h0 : (m_locked ? m_lock_data : write_req_data);
        acc = grant && mem_req_ready;
        pop = !RESET && mem_rsp_valid && tagq.size() > 0;
        rsp_who = pop ? tagq[0] : -1;

        check("mem_req_valid", mem_req_valid, grant);
        if (grant) begin
            check("mem_req_addr", mem_req_addr, e_addr);
            check("mem_req_write", mem_req_write, who == 2);
            check("mem_req_data", mem_req_data, e_data);
        end
        check("fetch_req_ready", fetch_req_ready, acc && who == 0);
        check("read_req_ready", read_req_ready, acc && who == 1);
        check("write_req_ready", write_req_ready, acc && who == 2);
        check("fetch_rsp_valid", fetch_rsp_valid, rsp_who == 0);
        check("read_rsp_valid", read_rsp_valid, rsp_who == 1);
        check("write_rsp_valid", write_rsp_valid, rsp_who == 2);
        if (rsp_who == 0) check("fetch_rsp_data", fetch_rsp_data, mem_rsp_data);
        if (rsp_who == 1) begin
            check("read_rsp_data", read_rsp_data, mem_rsp_data);
            check("read_rsp_resv", read_rsp_resv, mem_rsp_resv);
        end
        if (m_known) begin
            check("outstanding", outstanding, tagq.size());
            check("err_unexp_rsp", err_unexp_rsp, m_err);
        end

        if (RESET) begin
            tagq.delete(); m_locked = 0; m_starve = 0; m_err = 0; m_known = 1;
        end else begin
            if (mem_rsp_valid && tagq.size() == 0) m_err = 1;
            if (pop) void'(tagq.pop_front());
            if (acc) begin
                tagq.push_back(who); m_locked = 0;
            end else if (grant && !m_locked) begin
                m_locked = 1; m_lock_who = who; m_lock_addr = e_addr; m_lock_data = e_data;
            end
            if (fetch_req_valid && !(acc && who == 0))
                m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
            else
                m_starve = 0;
        end
        last_acc = acc; last_who = who;
        @(posedge CLK); #1;
    endtask

    task automatic drain();
        mem_req_ready = 0;
        for (int i = 0; i < 16 && tagq.size() > 0; i++) begin
            mem_rsp_valid = 1; mem_rsp_data = $urandom; mem_rsp_resv = 2'($urandom);
            step();
        end
        mem_rsp_valid = 0;
        check("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        int n;
        // Reset with every requester asking
        RESET = 1; fetch_req_valid = 1; read_req_valid = 1; write_req_valid = 1; mem_req_ready = 1;
        step(); step();
        check("rst_mem_req_valid", obs_req_valid, 0);
        check("rst_outstanding", obs_out, 0);
        RESET = 0; fetch_req_valid = 0; read_req_valid = 0; write_req_valid = 0;
        step();

        // Same-cycle requests issue in priority order, responses routed by tag
        fetch_req_valid = 1; fetch_req_addr = 32'h100;
        read_req_valid = 1;  read_req_addr = 32'h200;
        write_req_valid = 1; write_req_addr = 32'h300; write_req_data = 32'hDEAD;
        mem_req_ready = 1;
        step(); check("t2_issue0", obs_addr, 32'h300); write_req_valid = 0;
        step(); check("t2_issue1", obs_addr, 32'h200); read_req_valid = 0;
        step(); check("t2_issue2", obs_addr, 32'h100); fetch_req_valid = 0;
        mem_req_ready = 0; mem_rsp_valid = 1;
        mem_rsp_data = 32'hA; step(); check("t2_wr_ack", obs_wrv, 1);
        mem_rsp_data = 32'hB; step(); check("t2_rd_data", obs_rdata, 32'hB);
        mem_rsp_data = 32'hC; step(); check("t2_fe_data", obs_fdata, 32'hC);
        mem_rsp_valid = 0;

        // Grant held while memory stalls, later read does not steal it
        write_req_valid = 1; write_req_addr = 32'h300; write_req_data = 32'h55; mem_req_ready = 0;
        step();
        read_req_valid = 1; read_req_addr = 32'h400;
        step(); check("t3_hold_a", obs_addr, 32'h300);
        step(); check("t3_hold_b", obs_addr, 32'h300);
        mem_req_ready = 1;
        step(); check("t3_write_won", obs_wr, 1); write_req_valid = 0;
        step(); check("t3_read_next", obs_rr, 1); read_req_valid = 0;
        drain();

        // Fetch starvation promotion against a continuous read stream
        fetch_req_valid = 1; fetch_req_addr = 32'h500; read_req_valid = 1; mem_req_ready = 1;
        n = 20;
        for (int i = 1; i <= 20; i++) begin
            read_req_addr = 32'h1000 + 32'(i * 4);
            mem_rsp_valid = (tagq.size() > 0);
            step();
            if (obs_fr) begin n = i; break; end
        end
        check("t4_starve_cycles", n, 9);
        fetch_req_valid = 0; read_req_valid = 0;
        drain();

        // Outstanding limit, no pass-through on same-cycle response
        mem_req_ready = 1; read_req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            read_req_addr = 32'h2000 + 32'(i * 4);
            step();
        end
        read_req_addr = 32'h2010;
        step(); check("t5_full_block", obs_req_valid, 0);
        mem_rsp_valid = 1;
        step(); check("t5_pop_block", obs_rr, 0);
        mem_rsp_valid = 0;
        step(); check("t5_issue_after", obs_rr, 1);
        read_req_valid = 0;
        drain();

        // Unexpected response and reset with requests in flight
        mem_rsp_valid = 1; step();
        check("t6_no_rsp", {obs_frv, obs_rrv, obs_wrv}, 0);
        mem_rsp_valid = 0; step();
        check("t6_err_set", obs_err, 1);
        mem_req_ready = 1; read_req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            read_req_addr = 32'h3000 + 32'(i * 4);
            step();
        end
        read_req_valid = 0; step();
        check("t6_outst3", obs_out, 3);
        RESET = 1; step(); RESET = 0; step();
        check("t6_outst_rst", obs_out, 0);
        check("t6_err_rst", obs_err, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!fetch_req_valid && $urandom_range(2) == 0) begin
                fetch_req_valid = 1; fetch_req_addr = $urandom;
            end
            if (!read_req_valid && $urandom_range(3) == 0) begin
                read_req_valid = 1; read_req_addr = $urandom;
            end
            if (!write_req_valid && $urandom_range(4) == 0) begin
                write_req_valid = 1; write_req_addr = $urandom; write_req_data = $urandom;
            end
            mem_req_ready = ($urandom_range(3) != 0);
            mem_rsp_valid = (tagq.size() > 0) && ($urandom_range(1) == 0);
            mem_rsp_data = $urandom; mem_rsp_resv = 2'($urandom);
            step();
            if (last_acc) begin
                case (last_who)
                    0: fetch_req_valid = 0;
                    1: read_req_valid = 0;
                    default: write_req_valid = 0;
                endcase
            end
        end
        fetch_req_valid = 0; read_req_valid = 0; write_req_valid = 0;
        step();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
